// File: rtl/float_pkg.sv
// Shared definitions for the 8-bit {exp, mant} float format used by the encoder and adder.
// FLOAT_ENCODE_ROUND_EN adds the ROUND state to the encoder FSM.
package float_pkg;

  localparam int EXP_W  = 3;
  localparam int MANT_W = 5;
  localparam int INT_W  = MANT_W + (2 ** EXP_W) - 1;

  localparam logic [EXP_W+MANT_W-1:0] FLOAT_MAX = 8'hFF;
  // Largest exactly representable integer: 31 << 7.
  localparam logic [INT_W-1:0]        SAT_LIMIT = 12'd3968;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_DONE  = 2'd2
`ifdef FLOAT_ENCODE_ROUND_EN
    ,
    S_ROUND = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

endpackage

// File: rtl/float_encode.sv
// Iterative unsigned-integer to {exp, mant} float encoder, one normalising shift per clock.
// Define FLOAT_ENCODE_ROUND_EN for round-half-up; otherwise the mantissa is truncated.
module float_encode
  import float_pkg::*;
#(
  parameter int EXP_W  = float_pkg::EXP_W,
  parameter int MANT_W = float_pkg::MANT_W,
  parameter int INT_W  = float_pkg::INT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INT_W-1:0]        in_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] out_result,
  output logic                    out_sat,
  output logic                    out_inexact
);

  localparam logic [EXP_W-1:0]  EXP_MAX   = {EXP_W{1'b1}};
  localparam logic [MANT_W-1:0] MANT_HALF = {1'b1, {(MANT_W-1){1'b0}}};

  state_t             state, state_n;
  logic [INT_W-1:0]   work, work_n;
  logic [EXP_W-1:0]   exp_q, exp_n;
  logic               guard, guard_n;
  logic               sticky, sticky_n;
  logic               over, over_n;
  float_t             result_q, result_n;
  logic               sat_q, sat_n;
  logic               inexact_q, inexact_n;
  logic               fits;
`ifdef FLOAT_ENCODE_ROUND_EN
  logic [MANT_W:0]    mant_inc;
`endif

  assign fits = (work[INT_W-1:MANT_W] == '0);

  always_comb begin
    // NOTE: every signal driven here gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    state_n   = state;
    work_n    = work;
    exp_n     = exp_q;
    guard_n   = guard;
    sticky_n  = sticky;
    over_n    = over;
    result_n  = result_q;
    sat_n     = sat_q;
    inexact_n = inexact_q;
`ifdef FLOAT_ENCODE_ROUND_EN
    mant_inc  = {1'b0, work[MANT_W-1:0]} + {{MANT_W{1'b0}}, guard};
`endif

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          work_n   = in_value;
          exp_n    = '0;
          guard_n  = 1'b0;
          sticky_n = 1'b0;
          // Anything above SAT_LIMIT cannot be represented; remember it for the exit flags.
          over_n   = (in_value > SAT_LIMIT);
          state_n  = S_NORM;
        end
      end

      S_NORM: begin
        if (fits) begin
`ifdef FLOAT_ENCODE_ROUND_EN
          state_n = S_ROUND;
`else
          result_n.exp  = exp_q;
          result_n.mant = work[MANT_W-1:0];
          if (over) result_n = float_t'(FLOAT_MAX);
          sat_n     = over;
          inexact_n = guard | sticky | over;
          state_n   = S_DONE;
`endif
        end else if (exp_q == EXP_MAX) begin
          result_n  = float_t'(FLOAT_MAX);
          sat_n     = 1'b1;
          inexact_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          work_n   = work >> 1;
          guard_n  = work[0];
          sticky_n = sticky | guard;
          exp_n    = exp_q + 1'b1;
        end
      end

`ifdef FLOAT_ENCODE_ROUND_EN
      S_ROUND: begin
        result_n.exp  = exp_q;
        result_n.mant = mant_inc[MANT_W-1:0];
        sat_n         = over;
        inexact_n     = guard | sticky | over;
        if (over) begin
          result_n = float_t'(FLOAT_MAX);
        end else if (mant_inc[MANT_W]) begin
          // Mantissa carried out: renormalise to 16 << (exp+1), or clamp at the top exponent.
          if (exp_q == EXP_MAX) begin
            result_n = float_t'(FLOAT_MAX);
            sat_n    = 1'b1;
          end else begin
            result_n.exp  = exp_q + 1'b1;
            result_n.mant = MANT_HALF;
          end
        end
        state_n = S_DONE;
      end
`endif

      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      state     <= S_IDLE;
      work      <= '0;
      exp_q     <= '0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      over      <= 1'b0;
      result_q  <= '0;
      sat_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state     <= state_n;
      work      <= work_n;
      exp_q     <= exp_n;
      guard     <= guard_n;
      sticky    <= sticky_n;
      over      <= over_n;
      result_q  <= result_n;
      sat_q     <= sat_n;
      inexact_q <= inexact_n;
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign out_result  = result_q;
  assign out_sat     = sat_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_float_encode.sv
// Self-checking bench for float_encode: arithmetic reference model checked every cycle plus directed literal vectors.
`timescale 1ns/1ps
module tb_float_encode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_result;
  logic        out_sat;
  logic        out_inexact;

  int total = 0;
  int bad   = 0;

  float_encode dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sat(out_sat), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: smallest shift e that brings v under 32; value = mant << e.
  function automatic void model(input int v, output logic [7:0] r, output logic s,
                                output logic inx, output int lat);
    int e;
    int mant;
    e = 0;
    while ((v >> e) > 31) e++;
    mant = v >> e;
    inx  = (v & ((1 << e) - 1)) != 0;
    s    = (v > 3968);
    r    = s ? 8'hFF : {3'(e), 5'(mant)};
    lat  = e + 1;
`ifdef FLOAT_ENCODE_ROUND_EN
    lat = e + 2;
    if (!s && e > 0 && (((v >> (e - 1)) & 1) == 1)) begin
      mant++;
      if (mant == 32) begin
        if (e == 7) begin r = 8'hFF; s = 1'b1; end
        else r = {3'(e + 1), 5'd16};
      end else begin
        r = {3'(e), 5'(mant)};
      end
    end
`endif
  endfunction

  // Model state, advanced on the edges the DUT sees.
  int         cycle   = 0;
  int         acc     = 0;
  bit         pending = 0;
  bit         armed   = 0;
  logic [7:0] m_res;
  logic       m_sat, m_inx;
  int         m_lat   = 0;

  always @(posedge clk) begin
    cycle++;
    if (rst) begin
      pending = 0;
      armed   = 1;
    end else if (in_valid && in_ready) begin
      model(int'(in_value), m_res, m_sat, m_inx, m_lat);
      pending = 1;
      acc     = cycle;
    end else if (out_valid && out_ready) begin
      pending = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", 32'(in_ready), 32'(!pending));
      check("out_valid", 32'(out_valid), 32'(pending && (cycle - acc >= m_lat)));
      if (out_valid && pending) begin
        check("model_result", 32'(out_result), 32'(m_res));
        check("model_sat", 32'(out_sat), 32'(m_sat));
        check("model_inexact", 32'(out_inexact), 32'(m_inx));
      end
    end
  end

  // Waits for out_valid after the accept edge and checks literal expectations.
  task automatic wait_result(input string name, input logic [7:0] er, input logic es,
                             input logic ei, input int el);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin seen = 1; break; end
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(el));
    check({name, "_result"}, 32'(out_result), 32'(er));
    check({name, "_sat"}, 32'(out_sat), 32'(es));
    check({name, "_inexact"}, 32'(out_inexact), 32'(ei));
  endtask

  task automatic run(input string name, input int v, input logic [7:0] er, input logic es,
                     input logic ei, input int el, input bit release_out);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 12'(v);
    @(posedge clk);
    wait_result(name, er, es, ei, el);
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       s, x;
    int         l;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", 32'(out_result), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    model(100, r, s, x, l);
    check("pin_model_100", 32'(r), 32'h59);
    model(63, r, s, x, l);
`ifdef FLOAT_ENCODE_ROUND_EN
    check("pin_model_63", 32'(r), 32'h50);
`else
    check("pin_model_63", 32'(r), 32'h3F);
`endif
    model(4095, r, s, x, l);
    check("pin_model_4095_sat", 32'(s), 32'd1);

`ifdef FLOAT_ENCODE_ROUND_EN
    run("zero",  0,    8'h00, 1'b0, 1'b0, 2, 1);
    run("v100",  100,  8'h59, 1'b0, 1'b0, 4, 1);
    run("v31",   31,   8'h1F, 1'b0, 1'b0, 2, 1);
    run("v32",   32,   8'h30, 1'b0, 1'b0, 3, 1);
    run("v3968", 3968, 8'hFF, 1'b0, 1'b0, 9, 1);
    run("v4000", 4000, 8'hFF, 1'b1, 1'b1, 9, 1);
    run("v4095", 4095, 8'hFF, 1'b1, 1'b1, 9, 1);
    run("v102",  102,  8'h5A, 1'b0, 1'b1, 4, 1);
    run("v63",   63,   8'h50, 1'b0, 1'b1, 3, 1);
`else
    run("zero",  0,    8'h00, 1'b0, 1'b0, 1, 1);
    run("v100",  100,  8'h59, 1'b0, 1'b0, 3, 1);
    run("v31",   31,   8'h1F, 1'b0, 1'b0, 1, 1);
    run("v32",   32,   8'h30, 1'b0, 1'b0, 2, 1);
    run("v3968", 3968, 8'hFF, 1'b0, 1'b0, 8, 1);
    run("v4000", 4000, 8'hFF, 1'b1, 1'b1, 8, 1);
    run("v4095", 4095, 8'hFF, 1'b1, 1'b1, 8, 1);
    run("v102",  102,  8'h59, 1'b0, 1'b1, 3, 1);
    run("v63",   63,   8'h3F, 1'b0, 1'b1, 2, 1);
`endif

    // Backpressure: result held while a new value waits upstream.
`ifdef FLOAT_ENCODE_ROUND_EN
    run("bp100", 100, 8'h59, 1'b0, 1'b0, 4, 0);
`else
    run("bp100", 100, 8'h59, 1'b0, 1'b0, 3, 0);
`endif
    in_valid = 1'b1;
    in_value = 12'd31;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'(out_result), 32'h59);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
`ifdef FLOAT_ENCODE_ROUND_EN
    wait_result("bp31", 8'h1F, 1'b0, 1'b0, 2);
`else
    wait_result("bp31", 8'h1F, 1'b0, 1'b0, 1);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset sampled at edge A+4 while 4095 is normalising.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 12'd4095;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (i == 3) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_result", 32'(out_result), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef FLOAT_ENCODE_ROUND_EN
    run("post_rst100", 100, 8'h59, 1'b0, 1'b0, 4, 1);
`else
    run("post_rst100", 100, 8'h59, 1'b0, 1'b0, 3, 1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/float_encode.md
Name: float_encode

Overview:
- Sequential encoder that converts an unsigned 12-bit integer into the team's 8-bit float format: {exp[2:0], mant[4:0]}, where value ≈ mant << exp.
- This is the producer side for the float adder datapath. It generates operands in the exact format the adder consumes, including saturation to 8'hFF.
- Normalization is iterative: one right shift per clock. Input and output each use a valid/ready handshake.

Parameters:
- EXP_W, 3, exponent field width.
- MANT_W, 5, mantissa field width.
- INT_W, 12, input integer width. Must equal MANT_W + 2**EXP_W - 1. Other values are unsupported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_value is presented.
- in_ready  out  1  block can accept. High only in IDLE.
- in_value  in  INT_W  unsigned integer to encode.
- out_valid  out  1  out_result, out_sat and out_inexact are valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  EXP_W+MANT_W  encoded float.
- out_sat  out  1  input exceeded 31<<7 = 3968; result clamped to 8'hFF.
- out_inexact  out  1  at least one nonzero bit was discarded, or rounding changed the value.

Behaviour:
- Reset (rst=1 at an edge), whether idle or mid-operation:
  - state goes to IDLE and any conversion in progress is dropped;
  - out_valid=0, out_result=0, out_sat=0, out_inexact=0;
  - in_ready=1 in the following cycle.
- States: IDLE, NORM, ROUND (only when ROUND_EN is defined), DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - work <= in_value, exp <= 0, guard <= 0, sticky <= 0;
  - next state NORM.
- NORM, evaluated each edge:
  - If work[INT_W-1:MANT_W]==0 (fits): go to ROUND if enabled, else DONE with result {exp, work[4:0]}.
  - Else if exp==7: saturate. Result = 8'hFF, out_sat=1, go to DONE.
  - Else: work <= work>>1, guard <= work[0], sticky <= sticky|guard, exp <= exp+1.
- out_inexact = guard|sticky at the moment of exit, or 1 on saturation.
- Latency: let the accept edge be A and the number of shifts be e.
  - out_valid rises after edge A+e+1; after edge A+e+2 with ROUND_EN.
  - Saturation (e.g. 4095) rises after A+8.
- DONE:
  - out_valid=1; out_result, out_sat and out_inexact are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - A new input is accepted no earlier than the next cycle, so there is no same-cycle handoff.
- in_valid while busy is ignored (in_ready=0). The upstream side must hold its data.
- Zero input encodes to 8'h00, exact.
- Width rules: exp increments never wrap, because the exp==7 check precedes every shift. The mantissa is truncated unless ROUND_EN is defined.

Optional Feature:
- Macro: FLOAT_ENCODE_ROUND_EN.
- Defined: the ROUND state performs round-half-up.
  - If guard=1: mant <= mant+1 and out_inexact=1.
  - If the mantissa becomes 32: mant <= 16 and exp <= exp+1.
  - If exp was already 7: result 8'hFF with out_sat=1.
  - Costs one extra latency cycle.
- Undefined: ROUND state and its logic are absent; truncation only.

Decomposition:
- Shared package float_pkg holds:
  - EXP_W, MANT_W and INT_W constants;
  - FLOAT_MAX = 8'hFF;
  - SAT_LIMIT = 3968;
  - the state enum type;
  - a packed float typedef {exp, mant}.
- No sub-module: a single FSM plus datapath is the natural size.

Test Plan:
- in_value=0 → out_result=8'h00, sat=0, inexact=0; out_valid after edge A+1.
- in_value=100 → 8'h59 (exp=2, mant=25), inexact=0, out_valid after A+3. in_value=31 → 8'h1F after A+1.
- in_value=3968 → 8'hFF, sat=0, inexact=0. in_value=4095 → 8'hFF, sat=1, inexact=1, out_valid after A+8.
- Rounding cases:
  - in_value=102 → 8'h59 inexact=1 (truncating); with ROUND_EN → 8'h5A.
  - in_value=63 → 8'h3F truncating; with ROUND_EN → 8'h50 (mantissa overflow renormalizes).
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1 with a new value.
  - in_ready must stay 0 and out_result stay stable.
  - After out_ready=1, the block returns to IDLE and accepts the new value.
- Reset mid-operation: rst=1 at edge A+4 during conversion of 4095.
  - Next cycle: out_valid=0, out_result=0, in_ready=1.
  - A following conversion of 100 yields 8'h59.
